// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: register-index width and
// mul/div state encodings.
package issue_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

endpackage

// File: rtl/issue_tag_fifo.sv
// Synchronous FIFO of register tags; pop while empty is ignored, push while
// full is accepted only alongside a pop.
module issue_tag_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  reg_idx_t               data_i,
  output reg_idx_t               data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  reg_idx_t         mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: scoreboards long-latency writers, arbitrates the
// mul/div unit, tracks outstanding loads and serializes CSR instructions.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      dec_valid_i,
  input  reg_idx_t                  dec_reg_dr_i,
  input  reg_idx_t                  dec_reg_sr1_i,
  input  reg_idx_t                  dec_reg_sr2_i,
  input  logic                      dec_muldiv_i,
  input  logic                      dec_mem_ld_i,
  input  logic                      dec_csr_i,
  output logic                      iss_ready_o,
  output logic                      iss_valid_o,
  output logic                      md_start_o,
  output logic                      md_busy_o,
  input  logic                      md_done_i,
  output logic                      ld_issue_o,
  input  logic                      ld_resp_i,
  output logic [$clog2(LD_DEPTH):0] ld_cnt_o,
  output logic                      ld_err_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [0:0]          md_state_q, md_state_d;
  reg_idx_t            md_rd_q, md_rd_d;
  logic                ld_err_q, ld_err_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  reg_idx_t ld_tag;
  logic     ld_empty, ld_full, ld_pop;
  logic     haz, md_block, ld_block, csr_block, md_clear;

  issue_tag_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (ld_issue_o),
    .pop_i   (ld_resp_i),
    .data_i  (dec_reg_dr_i),
    .data_o  (ld_tag),
    .count_o (ld_cnt_o),
    .empty_o (ld_empty),
    .full_o  (ld_full)
  );

  // Issue decision uses registered state only; a writeback this cycle unblocks next cycle.
  assign haz = ((dec_reg_sr1_i != '0) & sb_q[dec_reg_sr1_i])
             | ((dec_reg_sr2_i != '0) & sb_q[dec_reg_sr2_i])
             | ((dec_reg_dr_i  != '0) & sb_q[dec_reg_dr_i]);
  assign md_block  = dec_muldiv_i & md_busy_o;
  assign ld_block  = dec_mem_ld_i & ld_full;
  assign csr_block = dec_csr_i & (md_busy_o | (ld_cnt_o != '0) | (sb_q != '0));

  assign iss_ready_o = rst_n_i & ~haz & ~md_block & ~ld_block & ~csr_block;
  assign iss_valid_o = dec_valid_i & iss_ready_o & ~flush_i;
  assign md_start_o  = iss_valid_o & dec_muldiv_i;
  assign ld_issue_o  = iss_valid_o & dec_mem_ld_i;
  assign md_busy_o   = (md_state_q == MD_BUSY);
  assign ld_err_o    = ld_err_q;
  assign stall_cnt_o = stall_q;

  assign ld_pop   = ld_resp_i & ~ld_empty;
  assign md_clear = md_busy_o & md_done_i;

  always_comb begin
    md_state_d = md_state_q;
    md_rd_d    = md_rd_q;
    case (md_state_q)
      MD_IDLE: if (md_start_o) begin
        md_state_d = MD_BUSY;
        md_rd_d    = dec_reg_dr_i;
      end
      MD_BUSY: if (md_done_i) md_state_d = MD_IDLE;
      default: md_state_d = MD_IDLE;
    endcase
  end

  // Clears first so a same-index set (only reachable if WAW were bypassed) wins.
  always_comb begin
    sb_d = sb_q;
    if (md_clear && md_rd_q != '0) sb_d[md_rd_q] = 1'b0;
    if (ld_pop && ld_tag != '0)    sb_d[ld_tag]  = 1'b0;
    if (iss_valid_o && (dec_muldiv_i || dec_mem_ld_i) && dec_reg_dr_i != '0)
      sb_d[dec_reg_dr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    ld_err_d = ld_err_q | (ld_resp_i & ld_empty);
    stall_d  = stall_q;
    if (dec_valid_i && !iss_ready_o && !flush_i && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sb_q       <= '0;
      md_state_q <= MD_IDLE;
      md_rd_q    <= '0;
      ld_err_q   <= 1'b0;
      stall_q    <= '0;
    end else begin
      sb_q       <= sb_d;
      md_state_q <= md_state_d;
      md_rd_q    <= md_rd_d;
      ld_err_q   <= ld_err_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       flush_i, dec_valid_i, dec_muldiv_i, dec_mem_ld_i, dec_csr_i;
  logic [4:0] dec_reg_dr_i, dec_reg_sr1_i, dec_reg_sr2_i;
  logic       iss_ready_o, iss_valid_o, md_start_o, md_busy_o, md_done_i;
  logic       ld_issue_o, ld_resp_i, ld_err_o;
  logic [2:0] ld_cnt_o;
  logic [15:0] stall_cnt_o;

  int tests = 0;
  int fails = 0;

  issue_ctrl #(.LD_DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .dec_valid_i(dec_valid_i),
    .dec_reg_dr_i(dec_reg_dr_i), .dec_reg_sr1_i(dec_reg_sr1_i), .dec_reg_sr2_i(dec_reg_sr2_i),
    .dec_muldiv_i(dec_muldiv_i), .dec_mem_ld_i(dec_mem_ld_i), .dec_csr_i(dec_csr_i),
    .iss_ready_o(iss_ready_o), .iss_valid_o(iss_valid_o), .md_start_o(md_start_o),
    .md_busy_o(md_busy_o), .md_done_i(md_done_i), .ld_issue_o(ld_issue_o),
    .ld_resp_i(ld_resp_i), .ld_cnt_o(ld_cnt_o), .ld_err_o(ld_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] dr, input logic [4:0] s1,
                       input logic [4:0] s2, input logic md, input logic ld, input logic csr);
    dec_valid_i = v; dec_reg_dr_i = dr; dec_reg_sr1_i = s1; dec_reg_sr2_i = s2;
    dec_muldiv_i = md; dec_mem_ld_i = ld; dec_csr_i = csr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; flush_i = 1'b0; md_done_i = 1'b0; ld_resp_i = 1'b0;
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready got %0b exp 0", iss_ready_o); end
    tests++; if (iss_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b exp 0", iss_valid_o); end
    tests++; if (ld_cnt_o !== 3'd0) begin fails++; $display("FAIL rst_ldcnt got %0d exp 0", ld_cnt_o); end
    tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL rst_stall got %0d exp 0", stall_cnt_o); end
    tests++; if (md_busy_o !== 1'b0 || ld_err_o !== 1'b0) begin fails++; $display("FAIL rst_busy_err got %0b%0b exp 00", md_busy_o, ld_err_o); end
    idle();
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_load_hazard();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    tests++; if (ld_issue_o !== 1'b1) begin fails++; $display("FAIL ld5_issue got %0b exp 1", ld_issue_o); end
    step();
    tests++; if (ld_cnt_o !== 3'd1) begin fails++; $display("FAIL ld5_cnt got %0d exp 1", ld_cnt_o); end
    drive(1'b1, 5'd6, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL raw_block got %0b exp 0", iss_ready_o); end
    step(); step(); step();
    tests++; if (stall_cnt_o !== 16'd3) begin fails++; $display("FAIL raw_stall got %0d exp 3", stall_cnt_o); end
    ld_resp_i = 1'b1;
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL raw_nobypass got %0b exp 0", iss_ready_o); end
    step();
    ld_resp_i = 1'b0;
    #1;
    tests++; if (ld_cnt_o !== 3'd0) begin fails++; $display("FAIL raw_cnt0 got %0d exp 0", ld_cnt_o); end
    tests++; if (stall_cnt_o !== 16'd4) begin fails++; $display("FAIL raw_stall4 got %0d exp 4", stall_cnt_o); end
    tests++; if (iss_valid_o !== 1'b1) begin fails++; $display("FAIL raw_issue got %0b exp 1", iss_valid_o); end
    step();
    idle();
  endtask

  task automatic test_muldiv();
    drive(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    #1;
    tests++; if (md_start_o !== 1'b1) begin fails++; $display("FAIL mul_start got %0b exp 1", md_start_o); end
    step();
    tests++; if (md_busy_o !== 1'b1) begin fails++; $display("FAIL mul_busy got %0b exp 1", md_busy_o); end
    drive(1'b1, 5'd8, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL div_block got %0b exp 0", iss_ready_o); end
    for (int i = 0; i < 9; i++) step();
    md_done_i = 1'b1;
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL div_done_cycle got %0b exp 0", iss_ready_o); end
    step();
    md_done_i = 1'b0;
    #1;
    tests++; if (md_busy_o !== 1'b0) begin fails++; $display("FAIL mul_idle got %0b exp 0", md_busy_o); end
    tests++; if (md_start_o !== 1'b1) begin fails++; $display("FAIL div_start got %0b exp 1", md_start_o); end
    tests++; if (stall_cnt_o !== 16'd14) begin fails++; $display("FAIL div_stall got %0d exp 14", stall_cnt_o); end
    step();
    idle();
    md_done_i = 1'b1;
    step();
    md_done_i = 1'b0;
    #1;
    tests++; if (md_busy_o !== 1'b0) begin fails++; $display("FAIL div_idle got %0b exp 0", md_busy_o); end
  endtask

  task automatic test_ld_fifo();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      tests++; if (ld_issue_o !== 1'b1) begin fails++; $display("FAIL ld_fill%0d got %0b exp 1", i, ld_issue_o); end
      step();
    end
    tests++; if (ld_cnt_o !== 3'd4) begin fails++; $display("FAIL ld_full_cnt got %0d exp 4", ld_cnt_o); end
    drive(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    ld_resp_i = 1'b1;
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL ld_full_block got %0b exp 0", iss_ready_o); end
    step();
    ld_resp_i = 1'b0;
    #1;
    tests++; if (ld_cnt_o !== 3'd3) begin fails++; $display("FAIL ld_pop_cnt got %0d exp 3", ld_cnt_o); end
    tests++; if (ld_issue_o !== 1'b1) begin fails++; $display("FAIL ld5_issue got %0b exp 1", ld_issue_o); end
    step();
    tests++; if (ld_cnt_o !== 3'd4) begin fails++; $display("FAIL ld5_cnt got %0d exp 4", ld_cnt_o); end
    idle();
    ld_resp_i = 1'b1;
    step();
    drive(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    tests++; if (ld_issue_o !== 1'b1) begin fails++; $display("FAIL ld_pushpop_issue got %0b exp 1", ld_issue_o); end
    step();
    ld_resp_i = 1'b0;
    #1;
    tests++; if (ld_cnt_o !== 3'd3) begin fails++; $display("FAIL ld_pushpop_cnt got %0d exp 3", ld_cnt_o); end
    drive(1'b1, 5'd20, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL x3_cleared got %0b exp 1", iss_ready_o); end
    drive(1'b1, 5'd20, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL x4_pending got %0b exp 0", iss_ready_o); end
    idle();
    ld_resp_i = 1'b1;
    step(); step(); step();
    ld_resp_i = 1'b0;
    #1;
    tests++; if (ld_cnt_o !== 3'd0) begin fails++; $display("FAIL ld_drain got %0d exp 0", ld_cnt_o); end
  endtask

  task automatic test_csr();
    drive(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd13, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL csr_block got %0b exp 0", iss_ready_o); end
    ld_resp_i = 1'b1;
    step();
    ld_resp_i = 1'b0;
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL csr_md_block got %0b exp 0", iss_ready_o); end
    md_done_i = 1'b1;
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL csr_done_cycle got %0b exp 0", iss_ready_o); end
    step();
    md_done_i = 1'b0;
    #1;
    tests++; if (iss_valid_o !== 1'b1) begin fails++; $display("FAIL csr_issue got %0b exp 1", iss_valid_o); end
    step();
    idle();
  endtask

  task automatic test_err_reset();
    ld_resp_i = 1'b1;
    step();
    ld_resp_i = 1'b0;
    step();
    tests++; if (ld_err_o !== 1'b1) begin fails++; $display("FAIL ld_err_sticky got %0b exp 1", ld_err_o); end
    drive(1'b1, 5'd15, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    #1;
    rst_n_i = 1'b0;
    #1;
    tests++; if (md_busy_o !== 1'b0) begin fails++; $display("FAIL arst_busy got %0b exp 0", md_busy_o); end
    tests++; if (ld_err_o !== 1'b0) begin fails++; $display("FAIL arst_err got %0b exp 0", ld_err_o); end
    tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL arst_stall got %0d exp 0", stall_cnt_o); end
    rst_n_i = 1'b1;
    drive(1'b1, 5'd21, 5'd15, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL arst_sb got %0b exp 1", iss_ready_o); end
    idle();
    step();
  endtask

  task automatic test_flush();
    flush_i = 1'b1;
    drive(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    #1;
    tests++; if (iss_valid_o !== 1'b0 || md_start_o !== 1'b0) begin fails++; $display("FAIL flush_issue got %0b%0b exp 00", iss_valid_o, md_start_o); end
    step();
    flush_i = 1'b0;
    tests++; if (md_busy_o !== 1'b0) begin fails++; $display("FAIL flush_busy got %0b exp 0", md_busy_o); end
    drive(1'b1, 5'd22, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL flush_sb9 got %0b exp 1", iss_ready_o); end
    step();
    drive(1'b1, 5'd16, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd17, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b1;
    md_done_i = 1'b1;
    #1;
    tests++; if (iss_valid_o !== 1'b0) begin fails++; $display("FAIL flush_busy_issue got %0b exp 0", iss_valid_o); end
    step();
    md_done_i = 1'b0;
    flush_i = 1'b0;
    tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL flush_stall got %0d exp 0", stall_cnt_o); end
    drive(1'b1, 5'd23, 5'd16, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL flush_sb16 got %0b exp 1", iss_ready_o); end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_load_hazard();
    test_muldiv();
    test_ld_fifo();
    test_csr();
    test_err_reset();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
